desc_feeder: RTL and testbench

DESC_FEEDER -- requirements
Module: desc_feeder

---
 rtl/desc_feeder_if.sv | 19 +
 rtl/desc_feeder.sv | 146 ++++++++++++++
 tb/tb_desc_feeder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/desc_feeder_if.sv
// Image descriptor memory read port.
// One-cycle read latency: data follows the issuing cycle.
interface desc_feeder_if;
    logic [10:0]  img_addr;
    logic         img_rd_en;
    logic [402:0] img_dout;

    modport master (
        output img_addr,
        output img_rd_en,
        input  img_dout
    );

    modport slave (
        input  img_addr,
        input  img_rd_en,
        output img_dout
    );
endinterface

// File: rtl/desc_feeder.sv
// Descriptor feeder: on each matcher request, fetches the next group
// of four keypoint descriptors and presents them on four slot registers.
module desc_feeder #(
    parameter logic [402:0] PAD_WORD = {403{1'b1}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [10:0]   kpt_num_i,
    input  logic          descriptor_request_i,
    output logic          descriptor_valid_o,
    desc_feeder_if.master mem,
    output logic [402:0]  image_R_C_D_0_o,
    output logic [402:0]  image_R_C_D_1_o,
    output logic [402:0]  image_R_C_D_2_o,
    output logic [402:0]  image_R_C_D_3_o,
    output logic [3:0]    slot_valid_o,
    output logic [8:0]    group_idx_o,
    output logic          busy_o,
    output logic          overrun_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_VALID = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]   state_q, state_d;
    logic [1:0]   k_q, k_d;
    logic [10:0]  base_q, base_d;
    logic [10:0]  kpt_lat_q, kpt_lat_d;
    logic [8:0]   group_q, group_d;
    logic [402:0] slot_q [4];
    logic [402:0] slot_d [4];
    logic [3:0]   slot_valid_q, slot_valid_d;
    logic         overrun_q, overrun_d;
    logic         pend_q, pend_d;
    logic [1:0]   pend_k_q, pend_k_d;
    logic         pend_en_q, pend_en_d;
    logic         block_q, block_d;

    logic [11:0]  addr12;
    logic         in_fetch;
    logic         rd_en;

    assign addr12   = {1'b0, base_q} + {10'd0, k_q};
    assign in_fetch = (state_q == S_FETCH);
    assign rd_en    = in_fetch && (addr12 < {1'b0, kpt_lat_q});

    assign mem.img_addr  = in_fetch ? addr12[10:0] : 11'd0;
    assign mem.img_rd_en = rd_en;

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        base_d       = base_q;
        kpt_lat_d    = kpt_lat_q;
        group_d      = group_q;
        slot_d       = slot_q;
        slot_valid_d = slot_valid_q;
        overrun_d    = overrun_q;
        pend_d       = 1'b0;
        pend_k_d     = k_q;
        pend_en_d    = rd_en;
        // A request held across VALID must drop before it can re-arm.
        block_d      = block_q & descriptor_request_i;

        if (pend_q) begin
            slot_d[pend_k_q]       = pend_en_q ? mem.img_dout : PAD_WORD;
            slot_valid_d[pend_k_q] = pend_en_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    kpt_lat_d = kpt_num_i;
                    base_d    = 11'd0;
                    group_d   = 9'd0;
                    overrun_d = 1'b0;
                end else if (descriptor_request_i && !block_q) begin
                    state_d = S_FETCH;
                    k_d     = 2'd0;
                    if (base_q >= kpt_lat_q) overrun_d = 1'b1;
                end
            end
            S_FETCH: begin
                pend_d = 1'b1;
                k_d    = k_q + 2'd1;
                if (k_q == 2'd3) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = S_VALID;
                // Index becomes visible together with descriptor_valid.
                group_d = base_q[10:2];
            end
            S_VALID: begin
                state_d = S_IDLE;
                base_d  = (base_q > 11'd2043) ? 11'd2047 : base_q + 11'd4;
                block_d = descriptor_request_i;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= 2'd0;
            base_q       <= 11'd0;
            kpt_lat_q    <= 11'd0;
            group_q      <= 9'd0;
            slot_q       <= '{default: '0};
            slot_valid_q <= 4'd0;
            overrun_q    <= 1'b0;
            pend_q       <= 1'b0;
            pend_k_q     <= 2'd0;
            pend_en_q    <= 1'b0;
            block_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            base_q       <= base_d;
            kpt_lat_q    <= kpt_lat_d;
            group_q      <= group_d;
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            overrun_q    <= overrun_d;
            pend_q       <= pend_d;
            pend_k_q     <= pend_k_d;
            pend_en_q    <= pend_en_d;
            block_q      <= block_d;
        end
    end

    assign descriptor_valid_o = (state_q == S_VALID);
    assign busy_o             = (state_q != S_IDLE);
    assign overrun_o          = overrun_q;
    assign group_idx_o        = group_q;
    assign slot_valid_o       = slot_valid_q;
    assign image_R_C_D_0_o    = slot_q[0];
    assign image_R_C_D_1_o    = slot_q[1];
    assign image_R_C_D_2_o    = slot_q[2];
    assign image_R_C_D_3_o    = slot_q[3];

endmodule

// File: tb/tb_desc_feeder.sv
// Bench for desc_feeder: timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_desc_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, req;
    logic [10:0]   kpt;
    logic          dv, busy, ovr;
    logic [402:0]  s0, s1, s2, s3;
    logic [3:0]    sv;
    logic [8:0]    gi;

    localparam logic [402:0] PAD = {403{1'b1}};

    desc_feeder_if mif();

    desc_feeder dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_i              (start),
        .kpt_num_i            (kpt),
        .descriptor_request_i (req),
        .descriptor_valid_o   (dv),
        .mem                  (mif.master),
        .image_R_C_D_0_o      (s0),
        .image_R_C_D_1_o      (s1),
        .image_R_C_D_2_o      (s2),
        .image_R_C_D_3_o      (s3),
        .slot_valid_o         (sv),
        .group_idx_o          (gi),
        .busy_o               (busy),
        .overrun_o            (ovr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_dv    = 0;

    function automatic logic [402:0] memword(int a);
        logic [402:0] w;
        logic [10:0]  ai;
        ai = a[10:0];
        w  = '0;
        for (int j = 0; j < 36; j++) w[j*11 +: 11] = ai ^ 11'(j * 37);
        w[402:396] = 7'h55;
        return w;
    endfunction

    task automatic chk(string nm, logic [402:0] act, logic [402:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Memory model; disabled cycles return junk so it cannot masquerade as data.
    always @(posedge clk) begin
        if (mif.img_rd_en) mif.img_dout <= memword(int'(mif.img_addr));
        else for (int j = 0; j < 13; j++) mif.img_dout[j*31 +: 31] <= 31'($urandom());
    end

    always @(posedge clk) cyc++;
    always @(negedge clk) if (dv === 1'b1) n_dv++;

    // Timeline model: offsets from the accepted request per the latency rules.
    bit           model_ok = 0;
    bit           has_acc, m_over, armed;
    int           m_kpt, m_base, m_group, acc_cyc, acc_base;
    logic [402:0] m_slots [4];
    logic [402:0] m_new [4];
    logic [3:0]   m_sv, m_new_sv;

    always @(negedge clk) begin
        int         off, a;
        logic [10:0] ea;
        logic       een;
        bit         idle;
        off = has_acc ? cyc - acc_cyc : 1000;
        if (model_ok) begin
            if (has_acc && off == 6) begin
                m_slots = m_new;
                m_sv    = m_new_sv;
            end
            ea = '0;
            een = 1'b0;
            if (off >= 1 && off <= 4) begin
                a   = acc_base + off - 1;
                ea  = a[10:0];
                een = (a < m_kpt);
            end
            chk("img_addr", mif.img_addr, ea);
            chk("img_rd_en", mif.img_rd_en, een);
            chk("desc_valid", dv, off == 6);
            chk("busy", busy, off >= 1 && off <= 6);
            chk("overrun", ovr, m_over);
            if (!has_acc || off <= 2 || off >= 6) begin
                chk("slot_valid", sv, m_sv);
                chk("slot0", s0, m_slots[0]);
                chk("slot1", s1, m_slots[1]);
                chk("slot2", s2, m_slots[2]);
                chk("slot3", s3, m_slots[3]);
            end
            if (off != 6) chk("group_idx", gi, m_group);
        end
        if (rst) begin
            model_ok = 1;
            has_acc  = 0;
            m_over   = 0;
            armed    = 1;
            m_kpt    = 0;
            m_base   = 0;
            m_group  = 0;
            m_sv     = '0;
            for (int i = 0; i < 4; i++) m_slots[i] = '0;
        end else if (model_ok) begin
            if (off == 6) begin
                m_base  = (m_base + 4 > 2047) ? 2047 : m_base + 4;
                m_group = acc_base / 4;
            end
            idle = (off >= 7);
            if (idle && start) begin
                m_kpt   = int'(kpt);
                m_base  = 0;
                m_group = 0;
                m_over  = 0;
            end else if (idle && req && armed) begin
                has_acc  = 1;
                acc_cyc  = cyc;
                acc_base = m_base;
                if (m_base >= m_kpt) m_over = 1;
                for (int i = 0; i < 4; i++) begin
                    m_new[i]    = (m_base + i < m_kpt) ? memword(m_base + i) : PAD;
                    m_new_sv[i] = (m_base + i < m_kpt);
                end
            end
            if (off == 6) armed = !req;
            else if (!req) armed = 1;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(int k);
        kpt   = 11'(k);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Ends inside the descriptor_valid cycle.
    task automatic request_group();
        req = 1'b1;
        tick(1);
        req = 1'b0;
        tick(5);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; req = 1'b0; kpt = '0;
        tick(3);
        chk("rst_sv", sv, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", mif.img_addr, 11'd0);
        chk("rst_slot0", s0, 403'd0);
        rst = 1'b0;
        tick(2);

        do_start(8);
        request_group();
        chk("g0_dv", dv, 1'b1);
        chk("g0_sv", sv, 4'hF);
        chk("g0_s0", s0, memword(0));
        chk("g0_s3", s3, memword(3));
        tick(1);
        chk("g0_gi", gi, 9'd0);
        request_group();
        chk("g1_sv", sv, 4'hF);
        chk("g1_s0", s0, memword(4));
        tick(1);
        chk("g1_gi", gi, 9'd1);
        chk("g1_ovr", ovr, 1'b0);
        request_group();
        chk("g2_dv", dv, 1'b1);
        chk("g2_sv", sv, 4'h0);
        chk("g2_s0", s0, PAD);
        chk("g2_s2", s2, PAD);
        tick(1);
        chk("g2_ovr", ovr, 1'b1);
        chk("g2_gi", gi, 9'd2);

        do_start(6);
        chk("k6_ovr_clr", ovr, 1'b0);
        request_group();
        tick(1);
        request_group();
        chk("k6_sv", sv, 4'b0011);
        chk("k6_s1", s1, memword(5));
        chk("k6_s2", s2, PAD);
        chk("k6_s3", s3, PAD);
        tick(1);

        do_start(20);
        d0  = n_dv;
        req = 1'b1;
        tick(6);
        chk("hold_dv", dv, 1'b1);
        tick(3);
        req = 1'b0;
        tick(2);
        chk("hold_once", n_dv - d0, 1);
        req = 1'b1;
        tick(6);
        chk("hold_rearm_dv", dv, 1'b1);
        req = 1'b0;
        tick(2);
        chk("hold_total", n_dv - d0, 2);

        do_start(100);
        req = 1'b1;
        tick(1);
        req = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rden", mif.img_rd_en, 1'b0);
        chk("mid_rst_sv", sv, 4'h0);
        tick(2);
        chk("mid_rst_s1", s1, 403'd0);
        chk("mid_rst_s2", s2, 403'd0);
        do_start(8);
        request_group();
        chk("post_rst_s0", s0, memword(0));

        tick(2);
        kpt = 11'd12; start = 1'b1; req = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        req = 1'b0; kpt = 11'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        chk("sr_dv", dv, 1'b1);
        chk("sr_sv", sv, 4'hF);
        tick(2);
        request_group();
        chk("sr_s0", s0, memword(4));
        chk("sr_sv2", sv, 4'hF);
        tick(1);
        chk("sr_gi", gi, 9'd1);

        do_start(0);
        request_group();
        chk("k0_sv", sv, 4'h0);
        chk("k0_s3", s3, PAD);
        tick(1);
        chk("k0_ovr", ovr, 1'b1);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
